card_dealer: RTL and testbench

//  Card source for the BlackJack datapath: holds a DECKS x 52-card shoe and deals one random, not-yet-dealt rank code per request.

---
 rtl/card_pkg.sv | 33 +++
 rtl/card_lfsr.sv | 23 ++
 rtl/card_dealer.sv | 158 +++++++++++++++
 tb/tb_card_dealer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared card encodings and FSM state type for the dealer slice.
// Rank code 0..12 = A,2..10,J,Q,K; helpers keep probe arithmetic in that range.
package card_pkg;
   localparam int CARD_W    = 4;
   localparam int NUM_RANKS = 13;

   localparam logic [CARD_W-1:0] RANK_A  = 4'd0;
   localparam logic [CARD_W-1:0] RANK_2  = 4'd1;
   localparam logic [CARD_W-1:0] RANK_3  = 4'd2;
   localparam logic [CARD_W-1:0] RANK_4  = 4'd3;
   localparam logic [CARD_W-1:0] RANK_5  = 4'd4;
   localparam logic [CARD_W-1:0] RANK_6  = 4'd5;
   localparam logic [CARD_W-1:0] RANK_7  = 4'd6;
   localparam logic [CARD_W-1:0] RANK_8  = 4'd7;
   localparam logic [CARD_W-1:0] RANK_9  = 4'd8;
   localparam logic [CARD_W-1:0] RANK_10 = 4'd9;
   localparam logic [CARD_W-1:0] RANK_J  = 4'd10;
   localparam logic [CARD_W-1:0] RANK_Q  = 4'd11;
   localparam logic [CARD_W-1:0] RANK_K  = 4'd12;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_DRAW = 1'b1
   } state_t;

   function automatic logic [CARD_W-1:0] rank_mod(input logic [CARD_W-1:0] v);
      return (v > RANK_K) ? v - 4'd13 : v;
   endfunction

   function automatic logic [CARD_W-1:0] next_rank(input logic [CARD_W-1:0] v);
      return (v >= RANK_K) ? RANK_A : v + 4'd1;
   endfunction
endpackage

// File: rtl/card_lfsr.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, loaded with SEED on reset.
// Advances every clock; no enable, no backpressure.
module card_lfsr #(
   parameter logic [15:0] SEED = 16'hACE1
) (
   input  logic        i_Clk,
   input  logic        i_Rst_n,
   output logic [15:0] q
);
   logic [15:0] lfsr_q;
   logic [15:0] lfsr_d;

   always_comb begin
      lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) lfsr_q <= SEED;
      else          lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q;
endmodule

// File: rtl/card_dealer.sv
// Shoe of DECKS x 52 cards dealing one random undealt rank per request; o_Valid 2..MAX_TRIES+14 cycles after i_Req,
// no queueing (requests ignored while busy or during the o_Valid cycle). DEALER_FORCE_EN adds forced-card ports.
module card_dealer
   import card_pkg::*;
#(
   parameter int          DECKS     = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          MAX_TRIES = 16
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic              i_Shuffle,
   input  logic              i_Req,
`ifdef DEALER_FORCE_EN
   input  logic              i_Force_Valid,
   input  logic [CARD_W-1:0] i_Force_Card,
`endif
   output logic [CARD_W-1:0] o_Card,
   output logic              o_Valid,
   output logic              o_Busy,
   output logic              o_Empty,
   output logic [7:0]        o_Remaining
);
   localparam int                TRY_W     = (MAX_TRIES < 1) ? 1 : $clog2(MAX_TRIES + 1);
   localparam logic [TRY_W-1:0]  TRY_MAX   = TRY_W'(MAX_TRIES);
   localparam logic [CARD_W-1:0] RANK_FULL = CARD_W'(4 * DECKS);
   localparam logic [7:0]        SHOE_FULL = 8'(52 * DECKS);

   logic [15:0]       lfsr;
   logic              lfsr_unused;
   logic [CARD_W-1:0] rand_cand;

   state_t            state_q, state_d;
   logic [TRY_W-1:0]  tries_q, tries_d;
   logic [CARD_W-1:0] probe_q, probe_d;
   logic [CARD_W-1:0] cnt_q [NUM_RANKS];
   logic [CARD_W-1:0] cnt_d [NUM_RANKS];
   logic [CARD_W-1:0] card_q, card_d;
   logic              valid_q, valid_d;
   logic              busy_q, busy_d;
   logic              empty_q, empty_d;
   logic [7:0]        remaining_q, remaining_d;

   logic [15:0]       avail;
   logic              random_phase;
   logic [CARD_W-1:0] cand;
   logic              force_hit;
   logic [CARD_W-1:0] force_card;
   logic              hit;
   logic [CARD_W-1:0] hit_card;

   card_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
      .i_Clk   (i_Clk),
      .i_Rst_n (i_Rst_n),
      .q       (lfsr)
   );

   assign rand_cand   = lfsr[3:0];
   assign lfsr_unused = ^lfsr[15:4];

   // Upper bits stay zero so any out-of-range candidate reads as unavailable.
   always_comb begin
      avail = '0;
      for (int i = 0; i < NUM_RANKS; i++) avail[i] = (cnt_q[i] != '0);
   end

   always_comb begin
      force_hit  = 1'b0;
      force_card = '0;
`ifdef DEALER_FORCE_EN
      force_card = i_Force_Card;
      force_hit  = i_Force_Valid && (i_Force_Card <= RANK_K) && avail[i_Force_Card]
                   && random_phase && (tries_q == '0);
`endif
   end

   always_comb begin
      state_d      = state_q;
      tries_d      = tries_q;
      probe_d      = probe_q;
      cnt_d        = cnt_q;
      card_d       = card_q;
      valid_d      = 1'b0;
      remaining_d  = remaining_q;
      hit          = 1'b0;
      hit_card     = '0;
      random_phase = (tries_q < TRY_MAX);
      cand         = random_phase ? rand_cand : probe_q;

      if (i_Shuffle) begin
         state_d     = ST_IDLE;
         remaining_d = SHOE_FULL;
         for (int i = 0; i < NUM_RANKS; i++) cnt_d[i] = RANK_FULL;
      end else if (state_q == ST_IDLE) begin
         if (i_Req && !empty_q && !valid_q) begin
            state_d = ST_DRAW;
            tries_d = '0;
            probe_d = rank_mod(rand_cand);
         end
      end else begin
         if (force_hit) begin
            hit      = 1'b1;
            hit_card = force_card;
         end else if ((cand <= RANK_K) && avail[cand]) begin
            hit      = 1'b1;
            hit_card = cand;
         end else if (random_phase) begin
            tries_d = tries_q + 1'b1;
            if (tries_d == TRY_MAX) probe_d = rank_mod(rand_cand);
         end else begin
            probe_d = next_rank(probe_q);
         end

         if (hit) begin
            state_d = ST_IDLE;
            card_d  = hit_card;
            valid_d = 1'b1;
            if (remaining_q != '0) remaining_d = remaining_q - 8'd1;
            for (int i = 0; i < NUM_RANKS; i++) begin
               if (hit_card == CARD_W'(i)) cnt_d[i] = cnt_q[i] - 1'b1;
            end
         end
      end

      busy_d  = (state_d == ST_DRAW);
      empty_d = (remaining_d == '0);
   end

   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q     <= ST_IDLE;
         tries_q     <= '0;
         probe_q     <= '0;
         card_q      <= '0;
         valid_q     <= 1'b0;
         busy_q      <= 1'b0;
         empty_q     <= 1'b0;
         remaining_q <= SHOE_FULL;
         for (int i = 0; i < NUM_RANKS; i++) cnt_q[i] <= RANK_FULL;
      end else begin
         state_q     <= state_d;
         tries_q     <= tries_d;
         probe_q     <= probe_d;
         card_q      <= card_d;
         valid_q     <= valid_d;
         busy_q      <= busy_d;
         empty_q     <= empty_d;
         remaining_q <= remaining_d;
         cnt_q       <= cnt_d;
      end
   end

   assign o_Card      = card_q;
   assign o_Valid     = valid_q;
   assign o_Busy      = busy_q;
   assign o_Empty     = empty_q;
   assign o_Remaining = remaining_q;
endmodule

// File: tb/tb_card_dealer.sv
// Bench for card_dealer: per-rank model plus a queue of expected o_Remaining values per accepted request.
module tb_card_dealer;
   localparam int DECKS     = 1;
   localparam int MAX_TRIES = 16;
   localparam int DEAL_TMO  = MAX_TRIES + 20;

   logic       clk;
   logic       rst_n;
   logic       shuffle;
   logic       req;
   logic [3:0] card;
   logic       valid;
   logic       busy;
   logic       empty;
   logic [7:0] remaining;
`ifdef DEALER_FORCE_EN
   logic       force_vld;
   logic [3:0] force_card;
`endif

   card_dealer #(.DECKS(DECKS), .LFSR_SEED(16'hACE1), .MAX_TRIES(MAX_TRIES)) dut (
      .i_Clk         (clk),
      .i_Rst_n       (rst_n),
      .i_Shuffle     (shuffle),
      .i_Req         (req),
`ifdef DEALER_FORCE_EN
      .i_Force_Valid (force_vld),
      .i_Force_Card  (force_card),
`endif
      .o_Card        (card),
      .o_Valid       (valid),
      .o_Busy        (busy),
      .o_Empty       (empty),
      .o_Remaining   (remaining)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int mcnt [13];
   int model_rem;
   int exp_q [$];
   int total_valids = 0;
   int cyc = 0;
   int last_valid_cyc = -100;
   bit free_mode = 1'b0;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 13; i++) mcnt[i] = 4 * DECKS;
      model_rem = 52 * DECKS;
      exp_q.delete();
   endtask

   always @(posedge clk) cyc++;

   // Every deal: legal rank, still available in the model, o_Remaining as predicted.
   always @(negedge clk) begin
      if (rst_n && valid) begin
         int exp_rem;
         total_valids++;
         check("valid_spacing", int'(cyc - last_valid_cyc >= 3), 1);
         last_valid_cyc = cyc;
         check("card_range", int'(card <= 4'd12), 1);
         if (card <= 4'd12) begin
            check("rank_avail", int'(mcnt[card] > 0), 1);
            if (mcnt[card] > 0) mcnt[card]--;
         end
         if (model_rem > 0) model_rem--;
         if (free_mode) begin
            check("remaining", int'(remaining), model_rem);
         end else if (exp_q.size() == 0) begin
            check("unexp_valid", 1, 0);
         end else begin
            exp_rem = exp_q.pop_front();
            check("remaining", int'(remaining), exp_rem);
         end
      end
   end

   task automatic deal();
      bit ok;
      int k;
      @(negedge clk);
      req = 1'b1;
      exp_q.push_back(model_rem - 1);
      @(negedge clk);
      req = 1'b0;
      ok = 1'b0;
      k  = 0;
      while (!ok && k < DEAL_TMO) begin
         @(negedge clk);
         if (valid) ok = 1'b1;
         k++;
      end
      check("deal_done", int'(ok), 1);
   endtask

   task automatic do_shuffle();
      @(negedge clk);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      model_reset();
      check("shuf_remaining", int'(remaining), 52 * DECKS);
      check("shuf_empty", int'(empty), 0);
   endtask

   initial begin
      int start;
      int last_rank;
      rst_n   = 1'b0;
      shuffle = 1'b0;
      req     = 1'b0;
`ifdef DEALER_FORCE_EN
      force_vld  = 1'b0;
      force_card = 4'd0;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_remaining", int'(remaining), 52 * DECKS);
      check("rst_empty", int'(empty), 0);
      check("rst_valid", int'(valid), 0);
      check("rst_card", int'(card), 0);
      check("rst_busy", int'(busy), 0);

      // Request held for three cycles yields exactly one card.
      start = total_valids;
      exp_q.push_back(model_rem - 1);
      @(negedge clk);
      req = 1'b1;
      repeat (3) @(negedge clk);
      req = 1'b0;
      repeat (DEAL_TMO) @(negedge clk);
      check("hold3_deals", total_valids - start, 1);
      do_shuffle();

      // Shuffle during DRAW aborts the draw.
      start = total_valids;
      @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      check("abort_busy", int'(busy), 1);
      shuffle = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      check("abort_remaining", int'(remaining), 52 * DECKS);
      check("abort_idle", int'(busy), 0);
      check("abort_valid", int'(valid), 0);
      repeat (DEAL_TMO) @(negedge clk);
      check("abort_no_deal", total_valids - start, 0);

      // Shuffle and request together in IDLE: no deal.
      start = total_valids;
      shuffle = 1'b1;
      req     = 1'b1;
      @(negedge clk);
      shuffle = 1'b0;
      req     = 1'b0;
      check("simul_busy", int'(busy), 0);
      repeat (DEAL_TMO) @(negedge clk);
      check("simul_no_deal", total_valids - start, 0);
      check("simul_remaining", int'(remaining), 52 * DECKS);

      // Request held long: deals spaced at least three cycles apart.
      start = total_valids;
      free_mode = 1'b1;
      req = 1'b1;
      repeat (30) @(negedge clk);
      req = 1'b0;
      repeat (DEAL_TMO) @(negedge clk);
      free_mode = 1'b0;
      check("hold_min", int'(total_valids - start >= 1), 1);
      check("hold_max", int'(total_valids - start <= 10), 1);
      do_shuffle();

`ifdef DEALER_FORCE_EN
      force_vld  = 1'b1;
      force_card = 4'd12;
      for (int i = 0; i < 5; i++) begin
         deal();
         if (i < 4) check("force_card", int'(card), 12);
         else       check("force_exhausted", int'(card != 4'd12), 1);
      end
      force_vld = 1'b0;
      do_shuffle();
`endif

      // Drain the shoe; the final card must be the single rank left.
      for (int i = 0; i < 52 * DECKS - 1; i++) deal();
      @(negedge clk);
      check("one_left", int'(remaining), 1);
      last_rank = -1;
      for (int i = 0; i < 13; i++) if (mcnt[i] > 0) last_rank = i;
      deal();
      check("last_rank", int'(card), last_rank);
      @(negedge clk);
      check("drained_remaining", int'(remaining), 0);
      check("drained_empty", int'(empty), 1);
      for (int i = 0; i < 13; i++) check("rank_total", mcnt[i], 0);

      start = total_valids;
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      repeat (100) @(negedge clk);
      check("empty_no_deal", total_valids - start, 0);
      do_shuffle();

      // Asynchronous reset in the middle of a draw.
      deal();
      deal();
      @(negedge clk);
      req = 1'b1;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      req   = 1'b0;
      #1;
      check("arst_valid", int'(valid), 0);
      check("arst_remaining", int'(remaining), 52 * DECKS);
      check("arst_busy", int'(busy), 0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (DEAL_TMO) @(negedge clk);
      check("arst_remaining_hold", int'(remaining), 52 * DECKS);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
